// File: rtl/hamming_disparity_ctrl.sv
// Winner-take-all disparity search: one shared 32-bit Hamming-distance unit scans a
// buffer of candidate census words against a reference word, one candidate per enabled cycle.
module hamming_disparity_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [1:0]  n,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StScan, StFin} state_e;

  localparam logic [1:0] OpLoadRef = 2'd0;
  localparam logic [1:0] OpPush    = 2'd1;
  localparam logic [1:0] OpSearch  = 2'd2;
  localparam logic [1:0] OpClear   = 2'd3;

  state_e            state_q, state_d;
  logic [31:0]       ref_q, ref_d;
  logic [31:0]       entry_q [DEPTH];
  logic [IDXW:0]     count_q, count_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [5:0]        best_cost_q, best_cost_d;
  logic [IDXW-1:0]   best_idx_q, best_idx_d;
  logic [5:0]        thr_q, thr_d;
  logic [31:0]       result_q, result_d;
  logic              done_q;
  logic              wr_en;
  logic [31:0]       diff;
  logic [5:0]        cost;
  logic              unused_datab;

  assign unused_datab = ^datab[31:6];

  // The single Hamming unit, fed by the candidate selected by idx.
  assign diff = ref_q ^ entry_q[idx_q];
  always_comb begin
    cost = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cost = cost + 6'(diff[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    count_d     = count_q;
    idx_d       = idx_q;
    best_cost_d = best_cost_q;
    best_idx_d  = best_idx_q;
    thr_d       = thr_q;
    result_d    = result_q;
    wr_en       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFin;
          unique case (n)
            OpLoadRef: begin
              ref_d       = dataa;
              best_cost_d = 6'd63;
              best_idx_d  = '0;
              result_d    = 32'd0;
            end
            OpPush: begin
              if (count_q < (IDXW + 1)'(DEPTH)) begin
                wr_en    = 1'b1;
                count_d  = count_q + 1'b1;
                result_d = {{(31 - IDXW){1'b0}}, count_d};
              end else begin
                result_d = {1'b1, {(30 - IDXW){1'b0}}, count_q};
              end
            end
            OpSearch: begin
              thr_d       = datab[5:0];
              idx_d       = '0;
              best_cost_d = 6'd63;
              best_idx_d  = '0;
              if (count_q == '0) begin
                result_d = 32'h8000_003F;
              end else begin
                state_d = StScan;
              end
            end
            OpClear: begin
              count_d  = '0;
              result_d = 32'd0;
            end
            default: ;
          endcase
        end
      end
      StScan: begin
        // Strict compare: on a tie the earlier (lower) index is kept.
        if (cost < best_cost_q) begin
          best_cost_d = cost;
          best_idx_d  = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if ({1'b0, idx_q} == count_q - 1'b1) begin
          state_d  = StFin;
          result_d = {(best_cost_d > thr_q), {(15 - IDXW){1'b0}}, best_idx_d, 10'd0,
                      best_cost_d};
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      ref_q       <= 32'd0;
      count_q     <= '0;
      idx_q       <= '0;
      best_cost_q <= 6'd63;
      best_idx_q  <= '0;
      thr_q       <= 6'd0;
      result_q    <= 32'd0;
      done_q      <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      best_cost_q <= best_cost_d;
      best_idx_q  <= best_idx_d;
      thr_q       <= thr_d;
      result_q    <= result_d;
      done_q      <= (state_d == StFin);
    end
  end

  // Candidate storage is deliberately not reset; count alone defines validity.
  always_ff @(posedge clk) begin
    if (reset && clk_en && wr_en) begin
      entry_q[count_q[IDXW-1:0]] <= dataa;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
